// File: rtl/brake_input_conditioner_if.sv
// Level-signal bundle between the handlebar brake switch and the brake light controller.
// All signals are plain levels in the c50M domain; there is no valid/ready handshake.
interface brake_input_conditioner_if;
    logic       brakeSwitchRaw;
    logic       flashEnable;
    logic       brakeActive;
    logic       brakeDebounced;
    logic       flashing;
    logic [2:0] fsm_state_dbg;

    modport master (
        output brakeSwitchRaw,
        output flashEnable,
        input  brakeActive,
        input  brakeDebounced,
        input  flashing,
        input  fsm_state_dbg
    );

    modport slave (
        input  brakeSwitchRaw,
        input  flashEnable,
        output brakeActive,
        output brakeDebounced,
        output flashing,
        output fsm_state_dbg
    );
endinterface

// File: rtl/brake_input_conditioner.sv
// Brake lever conditioner: 2-flop sync, debounce, onset flash burst and minimum lamp on-time.
// fsm_state_dbg exposes the FSM state register for checkers.
module brake_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned FLASH_HALF_CYCLES = 2500000,
    parameter int unsigned FLASH_COUNT       = 3,
    parameter int unsigned HOLD_CYCLES       = 10000000
) (
    input  logic c50M,
    input  logic reset_n,
    brake_input_conditioner_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(FLASH_HALF_CYCLES + 1);
    localparam int FW = $clog2(FLASH_COUNT + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FLASH_ON  = 3'd1,
        S_FLASH_OFF = 3'd2,
        S_STEADY    = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    logic          sync1_q, sync2_q;
    logic          sw_sync;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          deb_q, deb_d, deb_dly_q;
    logic          accept_rise;
    logic          press, release_ev;
    logic [HW-1:0] on_timer_q;
    logic          hold_met;
    state_t        state_q, state_d;
    logic [PW-1:0] phase_q;
    logic          phase_end;
    logic [FW-1:0] flash_cnt_q;
    logic          brake_active_q, flashing_q;

    always_ff @(posedge c50M or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.brakeSwitchRaw;
            sync2_q <= sync1_q;
        end
    end

    assign sw_sync = sync2_q;

    always_comb begin
        deb_cnt_d = '0;
        deb_d     = deb_q;
        if (sw_sync != deb_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = ~deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge c50M or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt_q <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
        end
    end

    assign accept_rise = deb_d & ~deb_q;
    assign press       = deb_q & ~deb_dly_q;
    assign release_ev  = ~deb_q & deb_dly_q;

    // The timer restarts on the edge that accepts the press, so it reads 0 during
    // the press-event cycle and holdMet lands exactly HOLD_CYCLES later.
    always_ff @(posedge c50M or negedge reset_n) begin
        if (!reset_n) begin
            on_timer_q <= '0;
        end else if (accept_rise) begin
            on_timer_q <= '0;
        end else if (on_timer_q != HW'(HOLD_CYCLES)) begin
            on_timer_q <= on_timer_q + HW'(1);
        end
    end

    assign hold_met  = (on_timer_q == HW'(HOLD_CYCLES));
    assign phase_end = (phase_q == PW'(FLASH_HALF_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (press) state_d = bus.flashEnable ? S_FLASH_ON : S_STEADY;
            end
            S_FLASH_ON: begin
                if (release_ev)     state_d = hold_met ? S_IDLE : S_HOLD;
                else if (phase_end) state_d = S_FLASH_OFF;
            end
            S_FLASH_OFF: begin
                if (release_ev)     state_d = hold_met ? S_IDLE : S_HOLD;
                else if (phase_end) state_d = (flash_cnt_q == FW'(FLASH_COUNT)) ? S_STEADY : S_FLASH_ON;
            end
            S_STEADY: begin
                if (release_ev) state_d = hold_met ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (press)         state_d = S_STEADY;
                else if (hold_met) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state_q.
    always_ff @(posedge c50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            phase_q        <= '0;
            flash_cnt_q    <= '0;
            brake_active_q <= 1'b0;
            flashing_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                phase_q <= '0;
            end else if (phase_q != PW'(FLASH_HALF_CYCLES)) begin
                phase_q <= phase_q + PW'(1);
            end
            if (state_q == S_IDLE && state_d == S_FLASH_ON) begin
                flash_cnt_q <= '0;
            end else if (state_q == S_FLASH_ON && state_d == S_FLASH_OFF) begin
                flash_cnt_q <= flash_cnt_q + FW'(1);
            end
            brake_active_q <= (state_d == S_FLASH_ON) || (state_d == S_STEADY) || (state_d == S_HOLD);
            flashing_q     <= (state_d == S_FLASH_ON) || (state_d == S_FLASH_OFF);
        end
    end

    assign bus.brakeActive    = brake_active_q;
    assign bus.brakeDebounced = deb_q;
    assign bus.flashing       = flashing_q;
    assign bus.fsm_state_dbg  = state_q;
endmodule

// File: doc/brake_input_conditioner.md
Name: brake_input_conditioner

Overview:
- Conditions the raw brake-lever switch into the clean `brakeActive` level consumed by the brake light controller.
- Processing chain: synchronise the raw switch, debounce it, then shape the result.
  - Shaping adds an optional onset "attention flash" burst.
  - Shaping also enforces a minimum lamp on-time so short taps stay visible.
- Sits between the handlebar brake switch input pin and the brake light controller. All logic runs in the 50 MHz domain.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a new switch level (10 ms).
- FLASH_HALF_CYCLES, 2500000, duration of each flash on-phase and each off-phase (50 ms).
- FLASH_COUNT, 3, number of on-phases in the onset burst; legal range is 1 or more.
- HOLD_CYCLES, 10000000, minimum brakeActive on-time measured from press acceptance (200 ms); must be at least 1.

Ports:
- c50M  input  1  50 MHz system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- brakeSwitchRaw  input  1  raw lever switch, active-high, asynchronous and bouncy.
- flashEnable  input  1  quasi-static; 1 enables the onset flash burst; sampled only at press acceptance.
- brakeActive  output  1  conditioned brake request to the brake light controller; registered.
- brakeDebounced  output  1  debounced switch level; registered.
- flashing  output  1  high while in FLASH_ON or FLASH_OFF; registered.

Behaviour:
- Clock and reset: one clock, c50M; asynchronous active-low reset `reset_n`.
- Reset values:
  - All outputs 0.
  - Synchroniser flops 0.
  - All counters 0.
  - FSM in IDLE.
  - Leaving reset mid-operation always restarts from IDLE with the lamp off.
- Synchroniser: 2-flop chain on brakeSwitchRaw, producing `swSync`.
- Debouncer:
  - Counter clears whenever `swSync` equals `brakeDebounced`.
  - Otherwise the counter increments each cycle; on reaching DEBOUNCE_CYCLES, `brakeDebounced` toggles and the counter clears.
  - Any reversion before the count completes clears the counter.
  - Latency from a raw edge to a `brakeDebounced` edge is 2 + DEBOUNCE_CYCLES cycles.
  - Press event = `brakeDebounced` rising edge; release event = falling edge (one-cycle pulses, internal).
- onTimer:
  - Cleared on every press event, then increments each cycle and saturates at HOLD_CYCLES.
  - `holdMet` = (onTimer == HOLD_CYCLES).
- FSM states: IDLE, FLASH_ON, FLASH_OFF, STEADY, HOLD.
- Outputs per state (registered; each output updates in the same cycle the state register updates, so brakeActive rises 1 cycle after the press event):
  - brakeActive = 1 in FLASH_ON, STEADY and HOLD; 0 in IDLE and FLASH_OFF.
  - flashing = 1 in FLASH_ON and FLASH_OFF.
- Phase counter: clears on every state entry; each flash phase lasts exactly FLASH_HALF_CYCLES cycles. A flash counter counts completed on-phases.
- IDLE:
  - On a press event with flashEnable=1, go to FLASH_ON with flash counter 0.
  - On a press event with flashEnable=0, go to STEADY.
- FLASH_ON: at phase end, increment the flash counter and go to FLASH_OFF.
- FLASH_OFF:
  - At phase end, if the flash counter equals FLASH_COUNT, go to STEADY; otherwise go to FLASH_ON.
  - The final off-phase is kept, so the lamp goes dark once before the steady-on.
- Release handling in any of FLASH_ON, FLASH_OFF or STEADY:
  - Release with holdMet=1: go to IDLE.
  - Release with holdMet=0: go to HOLD. Release takes priority over a phase end in the same cycle.
- HOLD:
  - When holdMet, go to IDLE.
  - A press event in HOLD goes to STEADY; there is no re-flash and onTimer restarts.
- IDLE with press and release impossible in the same cycle: the debouncer guarantees at least DEBOUNCE_CYCLES between edges.
- Width rules:
  - Each counter is sized with $clog2(parameter+1).
  - All compares are equality against the parameter; no wrap-around is possible because every counter either saturates or clears.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, FLASH_HALF_CYCLES=8, FLASH_COUNT=2, HOLD_CYCLES=40.
- Bounce rejection: raw toggles every 2 cycles for 20 cycles, then settles at 0 → brakeDebounced and brakeActive stay 0 throughout.
- Clean press with flashEnable=0 at cycle T:
  - brakeDebounced rises at T+6.
  - brakeActive rises at T+7; flashing stays 0.
- Flash burst with flashEnable=1 and a long press: brakeActive follows the pattern 8 on, 8 off, 8 on, 8 off, then steady 1; flashing is high for exactly 32 cycles.
- Short tap: debounced high for 10 cycles, flashEnable=0 → brakeActive stays high for exactly 40 cycles after it rises, then drops to 0.
- Re-press in HOLD: a second accepted press during HOLD → STEADY; no flash; brakeActive stays continuously 1 with no gap.
- Asynchronous reset mid-burst: assert reset_n=0 in FLASH_ON → all outputs 0 immediately without waiting for a clock edge. With the switch still held at release of reset, there is no press event until the debouncer re-accepts; then a full new burst runs.
